// File: rtl/game_pkg.sv
// Shared game constants and state encoding for the player
// controller and the sprite renderer.
package game_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_GAME = 2'd1,
        ST_WAIT = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int SPRITE_W  = 32;
    localparam int SPRITE_Y0 = 448;

endpackage

// File: rtl/tick_div.sv
// Free-running divider: one-cycle tick at count DIV-1, then wraps.
// clr forces the count to zero and takes priority over en.
module tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Count while enabled, wrap at terminal count, clear on request.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// Game-sequencing controller: game state, sprite x position,
// mouth animation phase and lives, all registered.
module player_ctrl
    import game_pkg::*;
#(
    parameter int MOVE_DIV    = 250000,
    parameter int STEP        = 4,
    parameter int X_MAX       = 608,
    parameter int X_HOME      = 304,
    parameter int ANIM_DIV    = 5000000,
    parameter int WAIT_CYCLES = 50000000,
    parameter int LIVES       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    input  logic       hit,
    output logic [9:0] position_x,
    output logic [1:0] state,
    output logic       mouth_open,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [9:0]  STEP10 = 10'(STEP);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [9:0]  XMAX10 = 10'(X_MAX);
    localparam logic [9:0]  HOME10 = 10'(X_HOME);
    localparam logic [1:0]  LIVES2 = 2'(LIVES);

    state_t      st;
    logic        start_q;
    logic        start_rise;
    logic        in_game;
    logic        in_wait;
    logic        move_tick;
    logic        anim_tick;
    logic        wait_tick;
    logic [10:0] pos_ext;
    logic [10:0] pos_inc;
    logic [9:0]  pos_left;
    logic [9:0]  pos_right;

    assign start_rise = btn_start && !start_q;
    assign in_game    = (st == ST_GAME);
    assign in_wait    = (st == ST_WAIT);
    assign state      = st;
    assign game_over  = (st == ST_OVER);

    // Saturating moves computed at 11 bits so nothing wraps.
    assign pos_ext   = {1'b0, position_x};
    assign pos_inc   = pos_ext + STEP11;
    assign pos_left  = (pos_ext >= STEP11) ? (position_x - STEP10) : 10'd0;
    assign pos_right = (pos_inc > XMAX11) ? XMAX10 : pos_inc[9:0];

    tick_div #(.DIV(MOVE_DIV)) u_move (
        .clk   (clk),
        .reset (reset),
        .clr   (!in_game),
        .en    (in_game),
        .tick  (move_tick)
    );

    tick_div #(.DIV(ANIM_DIV)) u_anim (
        .clk   (clk),
        .reset (reset),
        .clr   (!in_game),
        .en    (in_game),
        .tick  (anim_tick)
    );

    tick_div #(.DIV(WAIT_CYCLES)) u_wait (
        .clk   (clk),
        .reset (reset),
        .clr   (!in_wait),
        .en    (in_wait),
        .tick  (wait_tick)
    );

    // Game FSM with registered position, animation and lives.
    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= ST_INIT;
            start_q    <= 1'b1;
            position_x <= HOME10;
            mouth_open <= 1'b1;
            lives      <= LIVES2;
        end else begin
            start_q <= btn_start;
            case (st)
                ST_INIT: begin
                    mouth_open <= 1'b1;
                    if (start_rise) begin
                        st         <= ST_GAME;
                        lives      <= LIVES2;
                        position_x <= HOME10;
                    end
                end
                ST_GAME: begin
                    if (hit) begin
                        if (lives > 2'd1) begin
                            lives      <= lives - 2'd1;
                            mouth_open <= 1'b1;
                            st         <= ST_WAIT;
                        end else begin
                            lives <= 2'd0;
                            st    <= ST_OVER;
                        end
                    end else begin
                        if (move_tick && btn_left && !btn_right) begin
                            position_x <= pos_left;
                        end else if (move_tick && btn_right && !btn_left) begin
                            position_x <= pos_right;
                        end
                        if (anim_tick) begin
                            mouth_open <= !mouth_open;
                        end
                    end
                end
                ST_WAIT: begin
                    mouth_open <= 1'b1;
                    if (wait_tick) begin
                        st         <= ST_GAME;
                        position_x <= HOME10;
                    end
                end
                ST_OVER: begin
                    if (start_rise) begin
                        st         <= ST_INIT;
                        position_x <= HOME10;
                        mouth_open <= 1'b1;
                        lives      <= LIVES2;
                    end
                end
                default: begin
                    st <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: a cycle model pushes expected
// outputs as stimulus is driven; they are popped after each edge.
module tb_player_ctrl;

    localparam int MD = 4;
    localparam int AD = 8;
    localparam int WC = 10;
    localparam int SP = 4;
    localparam int XM = 608;
    localparam int XH = 304;
    localparam int LV = 2;

    typedef struct packed {
        logic [1:0] st;
        logic [9:0] pos;
        logic       mo;
        logic [1:0] lv;
        logic       go;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_start = 1'b1;
    logic       hit = 1'b0;
    logic [9:0] position_x;
    logic [1:0] state;
    logic       mouth_open;
    logic [1:0] lives;
    logic       game_over;

    int checks = 0;
    int failures = 0;

    exp_t sb[$];

    int m_st, m_pos, m_mo, m_lv, m_mc, m_ac, m_wc;
    bit m_sq;

    always #5 clk = ~clk;

    player_ctrl #(
        .MOVE_DIV    (MD),
        .STEP        (SP),
        .X_MAX       (XM),
        .X_HOME      (XH),
        .ANIM_DIV    (AD),
        .WAIT_CYCLES (WC),
        .LIVES       (LV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_start  (btn_start),
        .hit        (hit),
        .position_x (position_x),
        .state      (state),
        .mouth_open (mouth_open),
        .lives      (lives),
        .game_over  (game_over)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Behavioural reference: advances one clock with the given inputs.
    task automatic model(input bit r, input bit l, input bit rt,
                         input bit s, input bit h);
        bit rise, mt, at;
        if (r) begin
            m_st = 0; m_pos = XH; m_mo = 1; m_lv = LV;
            m_mc = 0; m_ac = 0; m_wc = 0; m_sq = 1;
            return;
        end
        rise = s && !m_sq;
        m_sq = s;
        case (m_st)
            0: begin
                m_mo = 1;
                if (rise) begin m_st = 1; m_lv = LV; m_pos = XH; end
            end
            1: begin
                mt = (m_mc == MD - 1);
                at = (m_ac == AD - 1);
                m_mc = mt ? 0 : m_mc + 1;
                m_ac = at ? 0 : m_ac + 1;
                if (h) begin
                    if (m_lv > 1) begin
                        m_lv = m_lv - 1; m_st = 2; m_mo = 1; m_wc = 0;
                    end else begin
                        m_lv = 0; m_st = 3;
                    end
                end else begin
                    if (mt && l && !rt) m_pos = (m_pos < SP) ? 0 : m_pos - SP;
                    if (mt && rt && !l) m_pos = (m_pos + SP > XM) ? XM : m_pos + SP;
                    if (at) m_mo = 1 - m_mo;
                end
            end
            2: begin
                m_mo = 1;
                if (m_wc == WC - 1) begin
                    m_st = 1; m_pos = XH; m_wc = 0;
                end else begin
                    m_wc++;
                end
            end
            default: begin
                if (rise) begin m_st = 0; m_pos = XH; m_mo = 1; m_lv = LV; end
            end
        endcase
        if (m_st != 1) begin m_mc = 0; m_ac = 0; end
    endtask

    // Drive one cycle of stimulus, push the model's expectation, then
    // pop and compare after the edge.
    task automatic cyc(input bit r, input bit l, input bit rt,
                       input bit s, input bit h);
        exp_t e, g;
        reset = r; btn_left = l; btn_right = rt; btn_start = s; hit = h;
        model(r, l, rt, s, h);
        e.st = 2'(m_st); e.pos = 10'(m_pos); e.mo = m_mo[0];
        e.lv = 2'(m_lv); e.go = (m_st == 3);
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("sb_state", state, g.st);
        chk("sb_pos", position_x, g.pos);
        chk("sb_mouth", mouth_open, g.mo);
        chk("sb_lives", lives, g.lv);
        chk("sb_over", game_over, g.go);
    endtask

    initial begin
        // reset with start held through and after reset
        repeat (3) cyc(1, 0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);
        chk("rst_state", state, 0);
        chk("rst_pos", position_x, 304);
        chk("rst_mouth", mouth_open, 1);
        chk("rst_lives", lives, 2);
        chk("rst_over", game_over, 0);

        // start and move right
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        chk("start_state", state, 1);
        repeat (4) cyc(0, 0, 1, 0, 0);
        chk("move_c4", position_x, 308);
        repeat (4) cyc(0, 0, 1, 0, 0);
        chk("move_c8", position_x, 312);
        chk("anim_c8", mouth_open, 0);

        // start held during GAME is ignored
        repeat (6) cyc(0, 0, 0, 1, 0);
        chk("start_ign", state, 1);
        cyc(0, 0, 0, 0, 0);

        // clamping at both ends and both-buttons hold
        repeat (400) cyc(0, 1, 0, 0, 0);
        chk("clamp_lo", position_x, 0);
        repeat (650) cyc(0, 0, 1, 0, 0);
        chk("clamp_hi", position_x, 608);
        repeat (20) cyc(0, 1, 1, 0, 0);
        chk("both_btn", position_x, 608);

        // hit with a life left; hits and buttons ignored in WAIT
        cyc(0, 0, 0, 0, 1);
        chk("hit_state", state, 2);
        chk("hit_lives", lives, 1);
        for (int i = 0; i < 9; i++) cyc(0, i[0], 1, 0, i[1]);
        chk("wait_c9", state, 2);
        cyc(0, 0, 0, 0, 1);
        chk("wait_end", state, 1);
        chk("wait_pos", position_x, 304);
        chk("wait_mouth", mouth_open, 1);
        chk("wait_lives", lives, 1);

        // last life lost on a move tick, then restart
        repeat (3) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1);
        chk("over_state", state, 3);
        chk("over_flag", game_over, 1);
        chk("over_lives", lives, 0);
        chk("over_pos", position_x, 304);
        repeat (5) cyc(0, 1, 0, 0, 1);
        chk("over_hold", position_x, 304);
        cyc(0, 0, 0, 1, 0);
        chk("restart_st", state, 0);
        chk("restart_lv", lives, 2);

        // mid-game reset
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        repeat (13) cyc(0, 1, 0, 1, 0);
        chk("mid_state", state, 1);
        cyc(1, 1, 0, 1, 1);
        chk("mid_rst_st", state, 0);
        chk("mid_rst_pos", position_x, 304);
        chk("mid_rst_mo", mouth_open, 1);
        chk("mid_rst_lv", lives, 2);
        chk("mid_rst_go", game_over, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);
        chk("mid_no_edge", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
